// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master (IBus/DBus) memory bus arbiter.
// Holds the FSM state encoding, the master ids and the arbitration policy codes.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic state_e grant_state(mst_e m);
    return (m == MST_D) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the IBus, DBus and memory-side signals around the arbiter.
// master = the arbiter's view; slave = the surrounding ICache/LSU/memory environment.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] i_IBus_Address;
  logic              i_IBus_Read;
  logic [DATA_W-1:0] o_IBus_ReadData;
  logic              o_IBus_WaitReq;

  logic [ADDR_W-1:0] i_DBus_Address;
  logic              i_DBus_Read;
  logic              i_DBus_Write;
  logic [DATA_W-1:0] i_DBus_WriteData;
  logic [BE_W-1:0]   i_DBus_ByteEnable;
  logic [DATA_W-1:0] o_DBus_ReadData;
  logic              o_DBus_WaitReq;

  logic [ADDR_W-1:0] o_Mem_Address;
  logic              o_Mem_Read;
  logic              o_Mem_Write;
  logic [DATA_W-1:0] o_Mem_WriteData;
  logic [BE_W-1:0]   o_Mem_ByteEnable;
  logic [DATA_W-1:0] i_Mem_ReadData;
  logic              i_Mem_WaitReq;

  modport master (
    input  i_IBus_Address, i_IBus_Read,
    output o_IBus_ReadData, o_IBus_WaitReq,
    input  i_DBus_Address, i_DBus_Read, i_DBus_Write, i_DBus_WriteData, i_DBus_ByteEnable,
    output o_DBus_ReadData, o_DBus_WaitReq,
    output o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_Mem_ByteEnable,
    input  i_Mem_ReadData, i_Mem_WaitReq
  );

  modport slave (
    output i_IBus_Address, i_IBus_Read,
    input  o_IBus_ReadData, o_IBus_WaitReq,
    output i_DBus_Address, i_DBus_Read, i_DBus_Write, i_DBus_WriteData, i_DBus_ByteEnable,
    input  o_DBus_ReadData, o_DBus_WaitReq,
    input  o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_Mem_ByteEnable,
    output i_Mem_ReadData, i_Mem_WaitReq
  );

endinterface

// File: rtl/bus_arb_pick.sv
// Combinational 2-way winner selection between IBus and DBus requests.
// Shared by the IDLE arbitration and the back-to-back handover after an acceptance.
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic req_i,
  input  logic req_d,
  input  mst_e last_grant,
  output logic valid,
  output mst_e winner
);

  // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    valid  = req_i | req_d;
    winner = MST_I;
    if (req_i && req_d) begin
      // Fixed mode always favours DBus; round-robin favours whoever was not served last.
      winner = (ARB_MODE == ARB_FIXED || last_grant == MST_I) ? MST_D : MST_I;
    end else if (req_d) begin
      winner = MST_D;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory bus between the ICache read port (IBus) and the CPU data port (DBus).
// One transaction in flight; read data is steered back to its owner one cycle after acceptance.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  bus_arbiter_if.master  bus
);

  localparam int BE_W = DATA_W / 8;

  state_e state_q, state_d;
  mst_e   last_grant_q, last_grant_d;
  logic   rd_pend_i_q, rd_pend_i_d;
  logic   rd_pend_d_q, rd_pend_d_d;

  logic req_i, req_d, d_is_wr, d_is_rd;
  logic pick_req_i, pick_req_d, pick_valid;
  mst_e pick_winner;
  logic accept;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_rd, mem_wr, wait_i, wait_d;

  // A simultaneous DBus read+write is treated as a write.
  assign req_i   = bus.i_IBus_Read;
  assign req_d   = bus.i_DBus_Read | bus.i_DBus_Write;
  assign d_is_wr = bus.i_DBus_Write;
  assign d_is_rd = bus.i_DBus_Read & ~bus.i_DBus_Write;

  // After an acceptance only the other master may take the bus next.
  always_comb begin
    pick_req_i = req_i;
    pick_req_d = req_d;
    if (state_q == GRANT_I) pick_req_i = 1'b0;
    if (state_q == GRANT_D) pick_req_d = 1'b0;
  end

  bus_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .req_i      (pick_req_i),
    .req_d      (pick_req_d),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_pend_i_d  = 1'b0;
    rd_pend_d_d  = 1'b0;
    accept       = 1'b0;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    mem_be       = '0;
    wait_i       = 1'b1;
    wait_d       = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = grant_state(pick_winner);
          last_grant_d = pick_winner;
        end
      end
      GRANT_I: begin
        mem_addr = bus.i_IBus_Address;
        mem_rd   = req_i;
        mem_be   = '1;
        wait_i   = bus.i_Mem_WaitReq;
        if (!req_i) begin
          state_d = IDLE;
        end else if (!bus.i_Mem_WaitReq) begin
          accept      = 1'b1;
          rd_pend_i_d = 1'b1;
        end
      end
      GRANT_D: begin
        mem_addr  = bus.i_DBus_Address;
        mem_rd    = d_is_rd;
        mem_wr    = d_is_wr;
        mem_wdata = bus.i_DBus_WriteData;
        mem_be    = bus.i_DBus_ByteEnable;
        wait_d    = bus.i_Mem_WaitReq;
        if (!req_d) begin
          state_d = IDLE;
        end else if (!bus.i_Mem_WaitReq) begin
          accept      = 1'b1;
          rd_pend_d_d = d_is_rd;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hand the bus straight to a waiting master, skipping the IDLE bubble.
    if (accept) begin
      if (pick_valid) begin
        state_d      = grant_state(pick_winner);
        last_grant_d = pick_winner;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      last_grant_q <= MST_I;
      rd_pend_i_q  <= 1'b0;
      rd_pend_d_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_pend_i_q  <= rd_pend_i_d;
      rd_pend_d_q  <= rd_pend_d_d;
    end
  end

  assign bus.o_Mem_Address    = mem_addr;
  assign bus.o_Mem_Read       = mem_rd;
  assign bus.o_Mem_Write      = mem_wr;
  assign bus.o_Mem_WriteData  = mem_wdata;
  assign bus.o_Mem_ByteEnable = mem_be;
  assign bus.o_IBus_WaitReq   = wait_i;
  assign bus.o_DBus_WaitReq   = wait_d;
  assign bus.o_IBus_ReadData  = rd_pend_i_q ? bus.i_Mem_ReadData : '0;
  assign bus.o_DBus_ReadData  = rd_pend_d_q ? bus.i_Mem_ReadData : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one round-robin and one fixed-priority instance.
// The memory model answers each accepted read with its own address, else with junk.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  bus_arbiter #(.ARB_MODE(0), .ADDR_W(32), .DATA_W(32)) dut0 (.i_Clk(clk), .i_Rst(rst0), .bus(bus0));
  bus_arbiter #(.ARB_MODE(1), .ADDR_W(32), .DATA_W(32)) dut1 (.i_Clk(clk), .i_Rst(rst1), .bus(bus1));

  always @(posedge clk) begin
    bus0.i_Mem_ReadData <= (bus0.o_Mem_Read && !bus0.i_Mem_WaitReq) ? bus0.o_Mem_Address : 32'hA5A5_A5A5;
    bus1.i_Mem_ReadData <= (bus1.o_Mem_Read && !bus1.i_Mem_WaitReq) ? bus1.o_Mem_Address : 32'hA5A5_A5A5;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.i_IBus_Address = '0; bus0.i_IBus_Read = 1'b0;
    bus0.i_DBus_Address = '0; bus0.i_DBus_Read = 1'b0; bus0.i_DBus_Write = 1'b0;
    bus0.i_DBus_WriteData = '0; bus0.i_DBus_ByteEnable = '0; bus0.i_Mem_WaitReq = 1'b0;
    bus1.i_IBus_Address = '0; bus1.i_IBus_Read = 1'b0;
    bus1.i_DBus_Address = '0; bus1.i_DBus_Read = 1'b0; bus1.i_DBus_Write = 1'b0;
    bus1.i_DBus_WriteData = '0; bus1.i_DBus_ByteEnable = '0; bus1.i_Mem_WaitReq = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc(); #2;
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL rst mem_read: got %b exp 0", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_Mem_Write !== 1'b0) begin n_fail++; $display("FAIL rst mem_write: got %b exp 0", bus0.o_Mem_Write); end
    n_checks++; if (bus0.o_Mem_Address !== 32'h0) begin n_fail++; $display("FAIL rst mem_addr: got %h exp 0", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_Mem_WriteData !== 32'h0) begin n_fail++; $display("FAIL rst mem_wdata: got %h exp 0", bus0.o_Mem_WriteData); end
    n_checks++; if (bus0.o_Mem_ByteEnable !== 4'h0) begin n_fail++; $display("FAIL rst mem_be: got %h exp 0", bus0.o_Mem_ByteEnable); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rst i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rst d_wait: got %b exp 1", bus0.o_DBus_WaitReq); end
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rst i_rdata: got %h exp 0", bus0.o_IBus_ReadData); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rst d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_ibus_read();
    cyc(); bus0.i_IBus_Address = 32'h4; bus0.i_IBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b0; #2;
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL ird idle i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL ird idle mem_read: got %b exp 0", bus0.o_Mem_Read); end
    cyc(); #2;
    n_checks++; if (bus0.o_Mem_Read !== 1'b1) begin n_fail++; $display("FAIL ird mem_read: got %b exp 1", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_Mem_Address !== 32'h4) begin n_fail++; $display("FAIL ird mem_addr: got %h exp 4", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL ird i_wait: got %b exp 0", bus0.o_IBus_WaitReq); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL ird d_wait: got %b exp 1", bus0.o_DBus_WaitReq); end
    n_checks++; if (bus0.o_Mem_Write !== 1'b0) begin n_fail++; $display("FAIL ird mem_write: got %b exp 0", bus0.o_Mem_Write); end
    n_checks++; if (bus0.o_Mem_ByteEnable !== 4'hF) begin n_fail++; $display("FAIL ird mem_be: got %h exp f", bus0.o_Mem_ByteEnable); end
    cyc(); bus0.i_IBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h4) begin n_fail++; $display("FAIL ird i_rdata: got %h exp 4", bus0.o_IBus_ReadData); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL ird d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL ird after i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    cyc(); #2;
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL ird i_rdata cleared: got %h exp 0", bus0.o_IBus_ReadData); end
  endtask

  task automatic test_ibus_wait();
    cyc(); bus0.i_IBus_Address = 32'h8; bus0.i_IBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b1; #2;
    for (int k = 0; k < 2; k++) begin
      cyc(); #2;
      n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL iwait stall%0d i_wait: got %b exp 1", k, bus0.o_IBus_WaitReq); end
      n_checks++; if (bus0.o_Mem_Address !== 32'h8) begin n_fail++; $display("FAIL iwait stall%0d mem_addr: got %h exp 8", k, bus0.o_Mem_Address); end
      n_checks++; if (bus0.o_Mem_Read !== 1'b1) begin n_fail++; $display("FAIL iwait stall%0d mem_read: got %b exp 1", k, bus0.o_Mem_Read); end
      n_checks++; if (bus0.o_IBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL iwait stall%0d i_rdata: got %h exp 0", k, bus0.o_IBus_ReadData); end
    end
    cyc(); bus0.i_Mem_WaitReq = 1'b0; #2;
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL iwait accept i_wait: got %b exp 0", bus0.o_IBus_WaitReq); end
    cyc(); bus0.i_IBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h8) begin n_fail++; $display("FAIL iwait i_rdata: got %h exp 8", bus0.o_IBus_ReadData); end
  endtask

  task automatic test_dbus_write();
    cyc();
    bus0.i_DBus_Address = 32'h100; bus0.i_DBus_WriteData = 32'hDEAD_BEEF; bus0.i_DBus_ByteEnable = 4'h3;
    bus0.i_DBus_Write = 1'b1; bus0.i_DBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b0; #2;
    cyc(); #2;
    n_checks++; if (bus0.o_Mem_Write !== 1'b1) begin n_fail++; $display("FAIL dwr mem_write: got %b exp 1", bus0.o_Mem_Write); end
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL dwr mem_read: got %b exp 0", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_Mem_Address !== 32'h100) begin n_fail++; $display("FAIL dwr mem_addr: got %h exp 100", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_Mem_WriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dwr mem_wdata: got %h exp deadbeef", bus0.o_Mem_WriteData); end
    n_checks++; if (bus0.o_Mem_ByteEnable !== 4'h3) begin n_fail++; $display("FAIL dwr mem_be: got %h exp 3", bus0.o_Mem_ByteEnable); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL dwr d_wait: got %b exp 0", bus0.o_DBus_WaitReq); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL dwr i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    cyc(); bus0.i_DBus_Write = 1'b0; bus0.i_DBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL dwr d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL dwr i_rdata: got %h exp 0", bus0.o_IBus_ReadData); end
    n_checks++; if (bus0.o_Mem_Write !== 1'b0) begin n_fail++; $display("FAIL dwr idle mem_write: got %b exp 0", bus0.o_Mem_Write); end
  endtask

  task automatic test_both_rr();
    cyc(); rst0 = 1'b1;
    cyc(); rst0 = 1'b0;
    bus0.i_IBus_Address = 32'h20; bus0.i_IBus_Read = 1'b1;
    bus0.i_DBus_Address = 32'h40; bus0.i_DBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b0; #2;
    cyc(); #2;
    n_checks++; if (bus0.o_Mem_Address !== 32'h40) begin n_fail++; $display("FAIL rr first mem_addr: got %h exp 40", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL rr first d_wait: got %b exp 0", bus0.o_DBus_WaitReq); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rr first i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    cyc(); bus0.i_DBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_Mem_Address !== 32'h20) begin n_fail++; $display("FAIL rr second mem_addr: got %h exp 20", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_Mem_Read !== 1'b1) begin n_fail++; $display("FAIL rr second mem_read: got %b exp 1", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL rr second i_wait: got %b exp 0", bus0.o_IBus_WaitReq); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h40) begin n_fail++; $display("FAIL rr d_rdata: got %h exp 40", bus0.o_DBus_ReadData); end
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rr i_rdata early: got %h exp 0", bus0.o_IBus_ReadData); end
    cyc(); bus0.i_IBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_IBus_ReadData !== 32'h20) begin n_fail++; $display("FAIL rr i_rdata: got %h exp 20", bus0.o_IBus_ReadData); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rr d_rdata late: got %h exp 0", bus0.o_DBus_ReadData); end
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL rr idle mem_read: got %b exp 0", bus0.o_Mem_Read); end
  endtask

  task automatic test_fixed_prio();
    cyc(); bus1.i_DBus_Address = 32'h10; bus1.i_DBus_Read = 1'b1; bus1.i_Mem_WaitReq = 1'b0; #2;
    cyc(); #2;
    n_checks++; if (bus1.o_Mem_Address !== 32'h10) begin n_fail++; $display("FAIL fix warm mem_addr: got %h exp 10", bus1.o_Mem_Address); end
    cyc();
    bus1.i_DBus_Address = 32'h50; bus1.i_IBus_Address = 32'h60; bus1.i_IBus_Read = 1'b1; #2;
    n_checks++; if (bus1.o_DBus_ReadData !== 32'h10) begin n_fail++; $display("FAIL fix warm d_rdata: got %h exp 10", bus1.o_DBus_ReadData); end
    n_checks++; if (bus1.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL fix idle mem_read: got %b exp 0", bus1.o_Mem_Read); end
    cyc(); #2;
    n_checks++; if (bus1.o_Mem_Address !== 32'h50) begin n_fail++; $display("FAIL fix first mem_addr: got %h exp 50", bus1.o_Mem_Address); end
    n_checks++; if (bus1.o_DBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL fix first d_wait: got %b exp 0", bus1.o_DBus_WaitReq); end
    n_checks++; if (bus1.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL fix first i_wait: got %b exp 1", bus1.o_IBus_WaitReq); end
    cyc(); bus1.i_DBus_Read = 1'b0; #2;
    n_checks++; if (bus1.o_Mem_Address !== 32'h60) begin n_fail++; $display("FAIL fix second mem_addr: got %h exp 60", bus1.o_Mem_Address); end
    n_checks++; if (bus1.o_IBus_WaitReq !== 1'b0) begin n_fail++; $display("FAIL fix second i_wait: got %b exp 0", bus1.o_IBus_WaitReq); end
    n_checks++; if (bus1.o_DBus_ReadData !== 32'h50) begin n_fail++; $display("FAIL fix d_rdata: got %h exp 50", bus1.o_DBus_ReadData); end
    cyc(); bus1.i_IBus_Read = 1'b0; #2;
    n_checks++; if (bus1.o_IBus_ReadData !== 32'h60) begin n_fail++; $display("FAIL fix i_rdata: got %h exp 60", bus1.o_IBus_ReadData); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, da, exp_addr, prev_addr;
    logic        owner_d;
    ia = 32'h1000; da = 32'h2000; prev_addr = '0;
    cyc(); rst0 = 1'b1;
    cyc(); rst0 = 1'b0;
    bus0.i_IBus_Address = ia; bus0.i_IBus_Read = 1'b1;
    bus0.i_DBus_Address = da; bus0.i_DBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b0;
    cyc(); #2;
    for (int t = 0; t < 8; t++) begin
      owner_d  = (t % 2 == 0);
      exp_addr = owner_d ? da : ia;
      n_checks++; if (bus0.o_Mem_Address !== exp_addr) begin n_fail++; $display("FAIL b2b t%0d mem_addr: got %h exp %h", t, bus0.o_Mem_Address, exp_addr); end
      n_checks++; if (bus0.o_Mem_Read !== 1'b1) begin n_fail++; $display("FAIL b2b t%0d mem_read: got %b exp 1", t, bus0.o_Mem_Read); end
      n_checks++; if (bus0.o_IBus_WaitReq !== owner_d) begin n_fail++; $display("FAIL b2b t%0d i_wait: got %b exp %b", t, bus0.o_IBus_WaitReq, owner_d); end
      n_checks++; if (bus0.o_DBus_WaitReq !== !owner_d) begin n_fail++; $display("FAIL b2b t%0d d_wait: got %b exp %b", t, bus0.o_DBus_WaitReq, !owner_d); end
      if (t > 0) begin
        n_checks++; if ((owner_d ? bus0.o_IBus_ReadData : bus0.o_DBus_ReadData) !== prev_addr) begin n_fail++; $display("FAIL b2b t%0d owner rdata: got %h exp %h", t, owner_d ? bus0.o_IBus_ReadData : bus0.o_DBus_ReadData, prev_addr); end
        n_checks++; if ((owner_d ? bus0.o_DBus_ReadData : bus0.o_IBus_ReadData) !== 32'h0) begin n_fail++; $display("FAIL b2b t%0d other rdata: got %h exp 0", t, owner_d ? bus0.o_DBus_ReadData : bus0.o_IBus_ReadData); end
      end
      if (t == 7) bus0.i_DBus_Read = 1'b0;
      cyc();
      prev_addr = exp_addr;
      if (owner_d) da = da + 32'h4; else ia = ia + 32'h4;
      bus0.i_IBus_Address = ia; bus0.i_DBus_Address = da;
      if (t == 7) bus0.i_IBus_Read = 1'b0;
      #2;
    end
    n_checks++; if (bus0.o_IBus_ReadData !== prev_addr) begin n_fail++; $display("FAIL b2b last i_rdata: got %h exp %h", bus0.o_IBus_ReadData, prev_addr); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL b2b last d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL b2b idle mem_read: got %b exp 0", bus0.o_Mem_Read); end
  endtask

  task automatic test_reset_mid();
    cyc(); bus0.i_DBus_Address = 32'h300; bus0.i_DBus_Read = 1'b1; bus0.i_Mem_WaitReq = 1'b1; #2;
    cyc(); rst0 = 1'b1; #2;
    n_checks++; if (bus0.o_Mem_Read !== 1'b1) begin n_fail++; $display("FAIL rmid pre mem_read: got %b exp 1", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rmid pre d_wait: got %b exp 1", bus0.o_DBus_WaitReq); end
    cyc(); rst0 = 1'b0; bus0.i_Mem_WaitReq = 1'b0; #2;
    n_checks++; if (bus0.o_Mem_Read !== 1'b0) begin n_fail++; $display("FAIL rmid mem_read: got %b exp 0", bus0.o_Mem_Read); end
    n_checks++; if (bus0.o_Mem_Write !== 1'b0) begin n_fail++; $display("FAIL rmid mem_write: got %b exp 0", bus0.o_Mem_Write); end
    n_checks++; if (bus0.o_Mem_Address !== 32'h0) begin n_fail++; $display("FAIL rmid mem_addr: got %h exp 0", bus0.o_Mem_Address); end
    n_checks++; if (bus0.o_IBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rmid i_wait: got %b exp 1", bus0.o_IBus_WaitReq); end
    n_checks++; if (bus0.o_DBus_WaitReq !== 1'b1) begin n_fail++; $display("FAIL rmid d_wait: got %b exp 1", bus0.o_DBus_WaitReq); end
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rmid d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    cyc(); bus0.i_DBus_Read = 1'b0; #2;
    n_checks++; if (bus0.o_DBus_ReadData !== 32'h0) begin n_fail++; $display("FAIL rmid late d_rdata: got %h exp 0", bus0.o_DBus_ReadData); end
    cyc(); #2;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_ibus_read();
    test_ibus_wait();
    test_dbus_write();
    test_both_rr();
    test_fixed_prio();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
